// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  localparam int PS2_FILTER_LEN     = 4;
  localparam int PS2_TIMEOUT_CYCLES = 1200;

  // Odd parity over the eight data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 pin synchronisers and ps2clk de-glitch filter
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2clk_i,
  input  logic ps2data_i,
  output logic data_sync_o,
  output logic fall_o
);

  localparam logic [FILTER_LEN-1:0] ALL_ONES = '1;

  logic                  clk_meta_q;
  logic                  clk_sync_q;
  logic                  data_meta_q;
  logic                  data_sync_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  clk_filt_q;
  logic                  fall_q;

  // Two-flop synchronisers, then a history of clock samples; the filtered
  // clock only moves once the whole history agrees on the opposite level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= ALL_ONES;
      clk_filt_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= ps2clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2data_i;
      data_sync_q <= data_meta_q;
      filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q};
      fall_q      <= 1'b0;
      if (filt_q == ALL_ONES) begin
        clk_filt_q <= 1'b1;
      end else if ((filt_q == '0) && clk_filt_q) begin
        clk_filt_q <= 1'b0;
        fall_q     <= 1'b1;
      end
    end
  end

  assign data_sync_o = data_sync_q;
  assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 deframer with E0/F0 prefix folding; optional frame timeout via PS2_FRAME_TIMEOUT_EN
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clock_12,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] scan_code,
  output logic       scan_extended,
  output logic       scan_break,
  output logic       scan_valid,
  output logic       frame_error
);

  logic data_sync;
  logic fall;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i       (clock_12),
    .rst_i       (reset),
    .ps2clk_i    (ps2clk),
    .ps2data_i   (ps2data),
    .data_sync_o (data_sync),
    .fall_o      (fall)
  );

  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] code_q, code_d;
  logic       sext_q, sext_d;
  logic       sbrk_q, sbrk_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

`ifdef PS2_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // State and output registers; reset abandons any frame without an error.
  always_ff @(posedge clock_12) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      code_q    <= 8'h00;
      sext_q    <= 1'b0;
      sbrk_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_FRAME_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      code_q    <= code_d;
      sext_q    <= sext_d;
      sbrk_q    <= sbrk_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef PS2_FRAME_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Frame sequencing on filtered clock falls; prefixes become flags on the next real code.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    code_d    = code_q;
    sext_d    = sext_q;
    sbrk_d    = sbrk_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_FRAME_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_sync) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = data_sync;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (ps2_parity_ok(shift_q, parity_q) && data_sync) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BREAK) begin
              brk_d = 1'b1;
            end else begin
              code_d  = shift_q;
              sext_d  = ext_q;
              sbrk_d  = brk_q;
              valid_d = 1'b1;
              ext_d   = 1'b0;
              brk_d   = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_FRAME_TIMEOUT_EN
    if (fall || (state_q == IDLE)) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = '0;
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
`endif
  end

  assign scan_code     = code_q;
  assign scan_extended = sext_q;
  assign scan_break    = sbrk_q;
  assign scan_valid    = valid_q;
  assign frame_error   = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

  logic       clock_12 = 1'b0;
  logic       reset;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] scan_code;
  logic       scan_extended;
  logic       scan_break;
  logic       scan_valid;
  logic       frame_error;

  ps2_keyboard_rx dut (
    .clock_12      (clock_12),
    .reset         (reset),
    .ps2clk        (ps2clk),
    .ps2data       (ps2data),
    .scan_code     (scan_code),
    .scan_extended (scan_extended),
    .scan_break    (scan_break),
    .scan_valid    (scan_valid),
    .frame_error   (frame_error)
  );

  always #5 clock_12 = ~clock_12;

`ifdef PS2_FRAME_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  cmp_ev;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_valid = 0;
  int   n_err   = 0;
  logic m_ext   = 1'b0;
  logic m_brk   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected outcome of one complete frame, from the protocol rules.
  task automatic model_frame(input logic [7:0] bv, input logic par, input logic stop);
    ev_t e;
    if (($countones({bv, par}) % 2 == 1) && stop) begin
      if (bv == 8'hE0) m_ext = 1'b1;
      else if (bv == 8'hF0) m_brk = 1'b1;
      else begin
        e = '{is_err: 1'b0, code: bv, ext: m_ext, brk: m_brk};
        exp_q.push_back(e);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else begin
      e = '{is_err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0};
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Every strobe must match the next expected event.
  always @(negedge clock_12) begin
    if (scan_valid || frame_error) begin
      if (scan_valid) n_valid++;
      if (frame_error) n_err++;
      check("strobe_exclusive", 32'(scan_valid & frame_error), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: valid=%0b err=%0b code=%0h, expected no event",
                 scan_valid, frame_error, scan_code);
      end else begin
        cmp_ev = exp_q.pop_front();
        check("event_is_err", 32'(frame_error), 32'(cmp_ev.is_err));
        if (!cmp_ev.is_err) begin
          check("event_code", 32'(scan_code), 32'(cmp_ev.code));
          check("event_ext", 32'(scan_extended), 32'(cmp_ev.ext));
          check("event_brk", 32'(scan_break), 32'(cmp_ev.brk));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock_12);
  endtask

  task automatic send_bit(input logic b, input int half);
    ps2data = b;
    wait_cycles(half / 2);
    ps2clk = 1'b0;
    wait_cycles(half);
    ps2clk = 1'b1;
    wait_cycles(half / 2);
  endtask

  task automatic send_frame(input logic [7:0] bv, input logic par_flip, input int half);
    logic par;
    par = ~(^bv) ^ par_flip;
    model_frame(bv, par, 1'b1);
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(bv[i], half);
    send_bit(par, half);
    send_bit(1'b1, half);
    ps2data = 1'b1;
    wait_cycles(20);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    int e0;
    reset   = 1'b1;
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    wait_cycles(5);
    @(negedge clock_12);
    check("rst_code", 32'(scan_code), 32'h00);
    check("rst_ext", 32'(scan_extended), 32'd0);
    check("rst_brk", 32'(scan_break), 32'd0);
    check("rst_valid", 32'(scan_valid), 32'd0);
    check("rst_err", 32'(frame_error), 32'd0);
    reset = 1'b0;
    wait_cycles(10);

    // Make code 'A' at the slow 1200-cycle clock period.
    v0 = n_valid;
    send_frame(8'h1C, 1'b0, 600);
    check_drained("a_drained");
    check("a_valid_count", n_valid - v0, 1);
    check("a_code", 32'(scan_code), 32'h1C);
    check("a_ext", 32'(scan_extended), 32'd0);
    check("a_brk", 32'(scan_break), 32'd0);

    // Release of 'A'.
    v0 = n_valid;
    send_frame(8'hF0, 1'b0, 60);
    check("brk_prefix_silent", n_valid - v0, 0);
    send_frame(8'h1C, 1'b0, 60);
    check_drained("brk_drained");
    check("brk_valid_count", n_valid - v0, 1);
    check("brk_code", 32'(scan_code), 32'h1C);
    check("brk_brk", 32'(scan_break), 32'd1);
    check("brk_ext", 32'(scan_extended), 32'd0);

    // Extended release, then a plain code with cleared flags.
    v0 = n_valid;
    send_frame(8'hE0, 1'b0, 60);
    send_frame(8'hF0, 1'b0, 60);
    send_frame(8'h75, 1'b0, 60);
    check_drained("ext_drained");
    check("ext_valid_count", n_valid - v0, 1);
    check("ext_code", 32'(scan_code), 32'h75);
    check("ext_ext", 32'(scan_extended), 32'd1);
    check("ext_brk", 32'(scan_break), 32'd1);
    send_frame(8'h1C, 1'b0, 60);
    check("plain_ext", 32'(scan_extended), 32'd0);
    check("plain_brk", 32'(scan_break), 32'd0);

    // Wrong parity, then recovery.
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h1C, 1'b1, 60);
    check("par_err_count", n_err - e0, 1);
    check("par_valid_count", n_valid - v0, 0);
    send_frame(8'h1C, 1'b0, 60);
    check_drained("par_drained");
    check("par_recover_valid", n_valid - v0, 1);
    check("par_recover_code", 32'(scan_code), 32'h1C);

    // Two-cycle ps2clk glitch with data low must not start a frame.
    v0 = n_valid;
    e0 = n_err;
    ps2data = 1'b0;
    ps2clk  = 1'b0;
    wait_cycles(2);
    ps2clk  = 1'b1;
    wait_cycles(30);
    ps2data = 1'b1;
    wait_cycles(10);
    send_frame(8'h29, 1'b0, 60);
    check_drained("glitch_drained");
    check("glitch_err_count", n_err - e0, 0);
    check("glitch_valid_count", n_valid - v0, 1);
    check("glitch_code", 32'(scan_code), 32'h29);

    // Clock stops after five data bits.
    e0 = n_err;
    send_bit(1'b0, 60);
    for (int i = 0; i < 5; i++) send_bit(((8'h1C >> i) & 8'h01) != 0, 60);
    if (TMO_EN) begin
      model_frame(8'h00, 1'b0, 1'b0);
    end
    ps2data = 1'b1;
    wait_cycles(1500);
    check_drained("tmo_drained");
    check("tmo_err_count", n_err - e0, TMO_EN ? 1 : 0);

    // Reset in the middle of a frame: silent, outputs cleared.
    send_bit(1'b0, 60);
    send_bit(1'b1, 60);
    e0 = n_err;
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(negedge clock_12);
    check("mid_rst_err_count", n_err - e0, 0);
    check("mid_rst_code", 32'(scan_code), 32'h00);
    check("mid_rst_flags", 32'({scan_extended, scan_break, scan_valid, frame_error}), 32'd0);
    ps2data = 1'b1;
    wait_cycles(20);
    v0 = n_valid;
    send_frame(8'h1C, 1'b0, 60);
    check_drained("post_rst_drained");
    check("post_rst_valid", n_valid - v0, 1);
    check("post_rst_code", 32'(scan_code), 32'h1C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
